// File: rtl/instr_fetch_dispatch_if.sv
// ============================================================================
//  Module   : instr_fetch_dispatch_if
//  Brief    : Memory, execute-handshake and status bundle for the fetch/dispatch stage.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface instr_fetch_dispatch_if #(
    parameter int ADDR_W = 8
) ();
    logic              run;
    logic [ADDR_W-1:0] pc;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [15:0]       mem_rdata;
    logic [15:0]       ir_out;
    logic              is_alu;
    logic              alu_done;
    logic              oth_done;
    logic              halted;
    logic              busy;
    logic [15:0]       retired;
    logic              wdog_err;

    modport master (
        input  run, pc, mem_ack, mem_rdata, alu_done, oth_done,
        output mem_rd, mem_addr, ir_out, is_alu, halted, busy, retired, wdog_err
    );

    modport slave (
        output run, pc, mem_ack, mem_rdata, alu_done, oth_done,
        input  mem_rd, mem_addr, ir_out, is_alu, halted, busy, retired, wdog_err
    );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_dispatch.sv
// ============================================================================
//  Module   : instr_fetch_dispatch
//  Brief    : Fetches one instruction, decodes its class and holds it in EXEC until
//             the owning execute FSM signals done. FETCH_WDOG_EN adds an EXEC timeout.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_fetch_dispatch #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    instr_fetch_dispatch_if.master bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_RETIRE = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [15:0]       ir_q;
    logic [15:0]       ir_out_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_rd_q;
    logic              is_alu_q;
    logic              halted_q;
    logic              busy_q;
    logic [15:0]       retired_q, retired_d;
    logic              done_w;
    logic              wdog_trip_w;
    logic              fetch_entry_w;

    // Only the done of the class that owns the instruction is honoured.
    assign done_w = is_alu_q ? bus.alu_done : bus.oth_done;

`ifdef FETCH_WDOG_EN
    localparam int WD_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [WD_W-1:0] wd_cnt_q;
    logic            wdog_err_q;

    // Counter holds the number of EXEC cycles already spent; trips on the TIMEOUT-th one.
    assign wdog_trip_w = (state_q == S_EXEC) && !done_w && (wd_cnt_q == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt_q   <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            if (state_q != S_EXEC) begin
                wd_cnt_q <= '0;
            end else begin
                wd_cnt_q <= wd_cnt_q + WD_W'(1);
            end
            if (wdog_trip_w) begin
                wdog_err_q <= 1'b1;
            end
        end
    end

    assign bus.wdog_err = wdog_err_q;
`else
    assign wdog_trip_w  = 1'b0;
    assign bus.wdog_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_HALT: if (bus.run)     state_d = S_FETCH;
            S_FETCH:        if (bus.mem_ack) state_d = S_DECODE;
            S_DECODE:       state_d = (ir_q[15:12] == 4'd0) ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (done_w) begin
                    state_d = S_RETIRE;
                end else if (wdog_trip_w) begin
                    state_d = S_HALT;
                end
            end
            S_RETIRE:       state_d = S_FETCH;
            default:        state_d = S_IDLE;
        endcase
    end

    assign retired_d     = (state_q == S_EXEC && done_w) ? retired_q + 16'd1 : retired_q;
    assign fetch_entry_w = (state_d == S_FETCH) && (state_q != S_FETCH);

    // All outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ir_q       <= '0;
            ir_out_q   <= '0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            is_alu_q   <= 1'b0;
            halted_q   <= 1'b0;
            busy_q     <= 1'b0;
            retired_q  <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            mem_rd_q  <= (state_d == S_FETCH);
            if (fetch_entry_w) begin
                mem_addr_q <= bus.pc;
            end
            if (state_q == S_FETCH && bus.mem_ack) begin
                ir_q <= bus.mem_rdata;
            end
            ir_out_q <= (state_d == S_EXEC) ? ir_q : 16'h0000;
            is_alu_q <= (state_d == S_EXEC) && (ir_q[15:12] >= 4'd9);
            halted_q <= (state_d == S_HALT);
            busy_q   <= (state_d inside {S_FETCH, S_DECODE, S_EXEC, S_RETIRE});
        end
    end

    assign bus.mem_rd   = mem_rd_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.ir_out   = ir_out_q;
    assign bus.is_alu   = is_alu_q;
    assign bus.halted   = halted_q;
    assign bus.busy     = busy_q;
    assign bus.retired  = retired_q;
endmodule

`default_nettype wire
